// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control unit.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, handshaking with
// instruction and data memory, and drives the per-state datapath strobes.
// The instruction class is captured once in DECODE; every later strobe comes
// from that registered decode, so the IR may change freely after DECODE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | imem_req until imem_ready; IRWrite on the ready cycle
//   DECODE | capture class/ALUOp/EXTOp/DMType/branch kind, or trap
//   EXEC   | ALU op; branches and jumps retire here
//   MEM    | dmem_req until dmem_ready; stores retire here
//   WB     | register write, PC+4, retire
//   TRAP   | illegal opcode or memory timeout; all strobes 0 until rst
module mc_ctrl #(
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic [6:0]         Funct7,
  input  logic [2:0]         Funct3,
  input  logic               Zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic [2:0]         EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         NPCOp,
  output logic [2:0]         DMType,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_err,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_JAL    = 3'd4;
  localparam logic [2:0] C_JALR   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;
  localparam logic [4:0] ALU_SUB   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_SLT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_XOR   = 5'd10;
  localparam logic [4:0] ALU_OR    = 5'd11;
  localparam logic [4:0] ALU_AND   = 5'd12;

  localparam logic [2:0] EXT_NONE = 3'b000;
  localparam logic [2:0] EXT_S    = 3'b001;
  localparam logic [2:0] EXT_I    = 3'b010;
  localparam logic [2:0] EXT_U    = 3'b011;
  localparam logic [2:0] EXT_B    = 3'b100;
  localparam logic [2:0] EXT_J    = 3'b101;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JALR = 3'b100;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // Wait counter only needs to reach MEM_TIMEOUT-1; the trap fires on the
  // non-ready cycle that would take it to MEM_TIMEOUT.
  localparam int             TW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         cls_q, cls_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [2:0]         extop_q, extop_d;
  logic [2:0]         dmtype_q, dmtype_d;
  logic               alusrc_q, alusrc_d;
  logic               brz_q, brz_d;
  logic [TW-1:0]      wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               dec_ok;
  logic [2:0]         dec_cls;
  logic [4:0]         dec_alu;
  logic [2:0]         dec_ext;
  logic [2:0]         dec_dmt;
  logic               dec_alusrc;
  logic               dec_brz;

  logic               to_hit;
  logic               waiting;
  logic               taken;
  logic               pc_write_raw;

  // Instruction decode from the IR fields; only consumed while in DECODE.
  always_comb begin
    dec_ok     = 1'b1;
    dec_cls    = C_ALU;
    dec_alu    = ALU_NOP;
    dec_ext    = EXT_NONE;
    dec_dmt    = DM_W;
    dec_alusrc = 1'b0;
    dec_brz    = 1'b0;
    case (Op)
      OP_R: begin
        if (Funct7 == F7_ZERO) begin
          case (Funct3)
            3'd0:    dec_alu = ALU_ADD;
            3'd1:    dec_alu = ALU_SLL;
            3'd2:    dec_alu = ALU_SLT;
            3'd3:    dec_alu = ALU_SLTU;
            3'd4:    dec_alu = ALU_XOR;
            3'd5:    dec_alu = ALU_SRL;
            3'd6:    dec_alu = ALU_OR;
            default: dec_alu = ALU_AND;
          endcase
        end else if (Funct7 == F7_ALT && Funct3 == 3'd0) begin
          dec_alu = ALU_SUB;
        end else if (Funct7 == F7_ALT && Funct3 == 3'd5) begin
          dec_alu = ALU_SRA;
        end else begin
          dec_ok = 1'b0;
        end
      end
      OP_I: begin
        dec_ext    = EXT_I;
        dec_alusrc = 1'b1;
        case (Funct3)
          3'd0: dec_alu = ALU_ADD;
          3'd2: dec_alu = ALU_SLT;
          3'd3: dec_alu = ALU_SLTU;
          3'd4: dec_alu = ALU_XOR;
          3'd6: dec_alu = ALU_OR;
          3'd7: dec_alu = ALU_AND;
          3'd1: begin
            if (Funct7 == F7_ZERO) dec_alu = ALU_SLL;
            else                   dec_ok  = 1'b0;
          end
          default: begin
            if (Funct7 == F7_ZERO)     dec_alu = ALU_SRL;
            else if (Funct7 == F7_ALT) dec_alu = ALU_SRA;
            else                       dec_ok  = 1'b0;
          end
        endcase
      end
      OP_LOAD: begin
        dec_cls    = C_LOAD;
        dec_ext    = EXT_I;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
        case (Funct3)
          3'd0:    dec_dmt = DM_B;
          3'd1:    dec_dmt = DM_H;
          3'd2:    dec_dmt = DM_W;
          3'd4:    dec_dmt = DM_BU;
          3'd5:    dec_dmt = DM_HU;
          default: dec_ok  = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec_cls    = C_STORE;
        dec_ext    = EXT_S;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
        case (Funct3)
          3'd0:    dec_dmt = DM_B;
          3'd1:    dec_dmt = DM_H;
          3'd2:    dec_dmt = DM_W;
          default: dec_ok  = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        dec_cls = C_BRANCH;
        dec_ext = EXT_B;
        // dec_brz: branch is taken when Zero is set (beq/bge/bgeu)
        case (Funct3)
          3'd0:    begin dec_alu = ALU_SUB;  dec_brz = 1'b1; end
          3'd1:    begin dec_alu = ALU_SUB;  dec_brz = 1'b0; end
          3'd4:    begin dec_alu = ALU_SLT;  dec_brz = 1'b0; end
          3'd5:    begin dec_alu = ALU_SLT;  dec_brz = 1'b1; end
          3'd6:    begin dec_alu = ALU_SLTU; dec_brz = 1'b0; end
          3'd7:    begin dec_alu = ALU_SLTU; dec_brz = 1'b1; end
          default: dec_ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec_cls = C_JAL;
        dec_ext = EXT_J;
      end
      OP_JALR: begin
        dec_cls    = C_JALR;
        dec_ext    = EXT_I;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_ADD;
        if (Funct3 != 3'd0) dec_ok = 1'b0;
      end
      OP_LUI: begin
        dec_ext    = EXT_U;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec_ext    = EXT_U;
        dec_alusrc = 1'b1;
        dec_alu    = ALU_AUIPC;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign to_hit  = (wait_q == TO_LAST);
  assign waiting = (state_q == S_FETCH && !imem_ready) ||
                   (state_q == S_MEM   && !dmem_ready);
  assign taken   = brz_q ? Zero : !Zero;

  // Next-state, sticky trap flags and per-state strobes.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    pc_write_raw = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    EXTOp        = EXT_NONE;
    ALUOp        = '0;
    NPCOp        = NPC_PC4;
    DMType       = DM_W;
    WDSel        = WD_ALU;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        ALUOp  = aluop_q;
        EXTOp  = extop_q;
        ALUSrc = alusrc_q;
        case (cls_q)
          C_ALU: state_d = S_WB;
          C_BRANCH: begin
            pc_write_raw = 1'b1;
            NPCOp        = taken ? NPC_BR : NPC_PC4;
            state_d      = S_FETCH;
          end
          C_JAL, C_JALR: begin
            RegWrite     = 1'b1;
            WDSel        = WD_PC4;
            pc_write_raw = 1'b1;
            NPCOp        = (cls_q == C_JAL) ? NPC_JAL : NPC_JALR;
            state_d      = S_FETCH;
          end
          C_LOAD, C_STORE: begin
            DMType  = dmtype_q;
            state_d = S_MEM;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        // Address operands stay asserted while the bus access is pending.
        ALUOp    = aluop_q;
        EXTOp    = extop_q;
        ALUSrc   = alusrc_q;
        DMType   = dmtype_q;
        dmem_req = 1'b1;
        MemWrite = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) begin
            pc_write_raw = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB: begin
        ALUOp        = aluop_q;
        EXTOp        = extop_q;
        ALUSrc       = alusrc_q;
        RegWrite     = 1'b1;
        pc_write_raw = 1'b1;
        if (cls_q == C_LOAD) begin
          WDSel  = WD_MEM;
          DMType = dmtype_q;
        end
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // A reset cycle must never commit architectural state, even mid-instruction.
    if (rst) begin
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      pc_write_raw = 1'b0;
      RegWrite     = 1'b0;
    end
  end

  assign PCWrite = pc_write_raw;

  // Memory-wait counter restarts on every state change.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + TW'(1);
  end

  // Decode capture happens only in DECODE; otherwise hold.
  always_comb begin
    cls_d    = cls_q;
    aluop_d  = aluop_q;
    extop_d  = extop_q;
    dmtype_d = dmtype_q;
    alusrc_d = alusrc_q;
    brz_d    = brz_q;
    if (state_q == S_DECODE) begin
      cls_d    = dec_cls;
      aluop_d  = ALUOP_W'(dec_alu);
      extop_d  = dec_ext;
      dmtype_d = dec_dmt;
      alusrc_d = dec_alusrc;
      brz_d    = dec_brz;
    end
  end

  // Every instruction retires on its single PCWrite.
  always_comb begin
    instret_d = instret_q;
    if (pc_write_raw) instret_d = instret_q + CNT_W'(1);
  end

  // State, decode, counters and sticky flags with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ALU;
      aluop_q   <= '0;
      extop_q   <= EXT_NONE;
      dmtype_q  <= DM_W;
      alusrc_q  <= 1'b0;
      brz_q     <= 1'b0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      aluop_q   <= aluop_d;
      extop_q   <= extop_d;
      dmtype_q  <= dmtype_d;
      alusrc_q  <= alusrc_d;
      brz_q     <= brz_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed vectors for mc_ctrl (MEM_TIMEOUT=4).
// Each table row is one clock: inputs applied after the falling edge,
// outputs compared 1 ns later, consumed by the next rising edge.
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;
  logic       Zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrc;
  logic [2:0] EXTOp, NPCOp, DMType, state;
  logic [4:0] ALUOp;
  logic [1:0] WDSel;
  logic       illegal, bus_err;
  logic [31:0] instret;

  mc_ctrl #(.ALUOP_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .NPCOp(NPCOp), .DMType(DMType), .WDSel(WDSel), .state(state),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  // {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrc}
  logic [6:0] stb;
  assign stb = {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrc};

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] F7A = 7'b0100000;

  typedef struct packed {
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        z;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [6:0]  stb;
    logic [2:0]  ext;
    logic [4:0]  alu;
    logic [2:0]  npc;
    logic [2:0]  dmt;
    logic [1:0]  wds;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                              input logic z, input logic ir, input logic dr,
                              input logic [2:0] st, input logic [6:0] s, input logic [2:0] ext,
                              input logic [4:0] alu, input logic [2:0] npc, input logic [2:0] dmt,
                              input logic [1:0] wds, input logic [31:0] ret);
    vec_t v;
    v.op = op; v.f7 = f7; v.f3 = f3; v.z = z; v.ir = ir; v.dr = dr;
    v.st = st; v.stb = s; v.ext = ext; v.alu = alu; v.npc = npc; v.dmt = dmt;
    v.wds = wds; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                     input logic z, input logic ir, input logic dr);
    @(negedge clk);
    rst = r; Op = op; Funct7 = f7; Funct3 = f3; Zero = z; imem_ready = ir; dmem_ready = dr;
    #1;
  endtask

  task automatic chk_st(input string nm, input logic [2:0] st, input logic [6:0] s);
    chk({nm, " state"}, state, st);
    chk({nm, " strobes"}, stb, s);
  endtask

  task automatic do_reset(input string nm);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk_st(nm, 3'd0, 7'b1000000);
    chk({nm, " illegal"}, illegal, 0);
    chk({nm, " bus_err"}, bus_err, 0);
    chk({nm, " instret"}, instret, 0);
    chk({nm, " fields"}, {EXTOp, ALUOp, NPCOp, DMType, WDSel}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1; Op = 0; Funct7 = 0; Funct3 = 0; Zero = 0; imem_ready = 0; dmem_ready = 0;

    // add: 4 cycles
    tbl.push_back(mk(R, 0, 0, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 0, 1, 1, 2, 7'b0000000, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(R, 0, 0, 0, 1, 1, 4, 7'b0000110, 0, 3, 0, 0, 0, 0));
    // lw with dmem_ready late by 3 cycles: 8 cycles
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 0, 7'b1001000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 1, 7'b0000000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 2, 7'b0000001, 2, 3, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 3, 7'b0100001, 2, 3, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 3, 7'b0100001, 2, 3, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 0, 3, 7'b0100001, 2, 3, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 1, 3, 7'b0100001, 2, 3, 0, 0, 0, 1));
    tbl.push_back(mk(LD, 0, 2, 0, 1, 1, 4, 7'b0000111, 2, 3, 0, 0, 1, 1));
    // bne, Zero=0: taken
    tbl.push_back(mk(BR, 0, 1, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BR, 0, 1, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(BR, 0, 1, 0, 1, 1, 2, 7'b0000100, 4, 4, 1, 0, 0, 2));
    // bne, Zero=1: not taken
    tbl.push_back(mk(BR, 0, 1, 1, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(BR, 0, 1, 1, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(BR, 0, 1, 1, 1, 1, 2, 7'b0000100, 4, 4, 0, 0, 0, 3));
    // bge, Zero=1: taken, slt
    tbl.push_back(mk(BR, 0, 5, 1, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(BR, 0, 5, 1, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(BR, 0, 5, 1, 1, 1, 2, 7'b0000100, 4, 8, 1, 0, 0, 4));
    // jal
    tbl.push_back(mk(JL, 0, 0, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(JL, 0, 0, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 5));
    tbl.push_back(mk(JL, 0, 0, 0, 1, 1, 2, 7'b0000110, 5, 0, 2, 0, 2, 5));
    // sb with two fetch wait cycles
    tbl.push_back(mk(ST, 0, 0, 0, 0, 1, 0, 7'b1000000, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ST, 0, 0, 0, 0, 1, 0, 7'b1000000, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ST, 0, 0, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ST, 0, 0, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(ST, 0, 0, 0, 1, 1, 2, 7'b0000001, 1, 3, 0, 3, 0, 6));
    tbl.push_back(mk(ST, 0, 0, 0, 1, 1, 3, 7'b0110101, 1, 3, 0, 3, 0, 6));
    // srai
    tbl.push_back(mk(IA, F7A, 5, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(IA, F7A, 5, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 7));
    tbl.push_back(mk(IA, F7A, 5, 0, 1, 1, 2, 7'b0000001, 2, 7, 0, 0, 0, 7));
    tbl.push_back(mk(IA, F7A, 5, 0, 1, 1, 4, 7'b0000111, 2, 7, 0, 0, 0, 7));
    // lui
    tbl.push_back(mk(LU, 0, 0, 0, 1, 1, 0, 7'b1001000, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(LU, 0, 0, 0, 1, 1, 1, 7'b0000000, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(LU, 0, 0, 0, 1, 1, 2, 7'b0000001, 3, 1, 0, 0, 0, 8));
    tbl.push_back(mk(LU, 0, 0, 0, 1, 1, 4, 7'b0000111, 3, 1, 0, 0, 0, 8));
    tbl.push_back(mk(LU, 0, 0, 0, 0, 1, 0, 7'b1000000, 0, 0, 0, 0, 0, 9));

    do_reset("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      cyc(0, v.op, v.f7, v.f3, v.z, v.ir, v.dr);
      chk($sformatf("row%0d state", i), state, v.st);
      chk($sformatf("row%0d strobes", i), stb, v.stb);
      chk($sformatf("row%0d EXTOp", i), EXTOp, v.ext);
      chk($sformatf("row%0d ALUOp", i), ALUOp, v.alu);
      chk($sformatf("row%0d NPCOp", i), NPCOp, v.npc);
      chk($sformatf("row%0d DMType", i), DMType, v.dmt);
      chk($sformatf("row%0d WDSel", i), WDSel, v.wds);
      chk($sformatf("row%0d instret", i), instret, v.ret);
      chk($sformatf("row%0d flags", i), {illegal, bus_err}, 0);
    end

    // Unknown opcode: trap after DECODE and stay there.
    cyc(0, 7'h7f, 0, 0, 0, 1, 1); chk_st("ill fetch", 0, 7'b1001000);
    cyc(0, 7'h7f, 0, 0, 0, 1, 1); chk_st("ill decode", 1, 7'b0000000);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 7'h7f, 0, 0, 0, 1, 1);
      chk_st("ill trap", 7, 7'b0000000);
      chk("ill flag", illegal, 1);
      chk("ill instret", instret, 9);
    end
    do_reset("reset after ill");

    // R-type with funct7=0100000 and funct3=sll is not an instruction.
    cyc(0, R, F7A, 1, 0, 1, 1); chk_st("badf7 fetch", 0, 7'b1001000);
    cyc(0, R, F7A, 1, 0, 1, 1); chk_st("badf7 decode", 1, 7'b0000000);
    cyc(0, R, F7A, 1, 0, 1, 1); chk_st("badf7 trap", 7, 7'b0000000);
    chk("badf7 illegal", illegal, 1);
    chk("badf7 bus_err", bus_err, 0);
    do_reset("reset after badf7");

    // sw with dmem_ready never arriving: trap after 4 wait cycles.
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("to fetch", 0, 7'b1001000);
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("to decode", 1, 7'b0000000);
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("to exec", 2, 7'b0000001);
    for (int k = 0; k < 4; k++) begin
      cyc(0, ST, 0, 2, 0, 1, 0);
      chk_st($sformatf("to mem%0d", k), 3, 7'b0110001);
      chk("to no bus_err yet", bus_err, 0);
    end
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("to trap", 7, 7'b0000000);
    chk("to bus_err", bus_err, 1);
    chk("to illegal", illegal, 0);
    cyc(0, ST, 0, 2, 0, 1, 1); chk_st("to trap held", 7, 7'b0000000);
    do_reset("reset after to");

    // Ready on the 4th wait cycle wins over the timeout.
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("rw fetch", 0, 7'b1001000);
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("rw decode", 1, 7'b0000000);
    cyc(0, ST, 0, 2, 0, 1, 0); chk_st("rw exec", 2, 7'b0000001);
    for (int k = 0; k < 3; k++) begin
      cyc(0, ST, 0, 2, 0, 1, 0);
      chk_st($sformatf("rw mem%0d", k), 3, 7'b0110001);
    end
    cyc(0, ST, 0, 2, 0, 1, 1); chk_st("rw mem ready", 3, 7'b0110101);
    cyc(0, ST, 0, 2, 0, 0, 0); chk_st("rw done", 0, 7'b1000000);
    chk("rw bus_err", bus_err, 0);
    chk("rw instret", instret, 1);
    // Fetch side timeout: 4 non-ready fetch cycles counting the one above.
    for (int k = 0; k < 3; k++) begin
      cyc(0, ST, 0, 2, 0, 0, 0);
      chk_st($sformatf("fto wait%0d", k), 0, 7'b1000000);
    end
    cyc(0, ST, 0, 2, 0, 0, 0); chk_st("fto trap", 7, 7'b0000000);
    chk("fto bus_err", bus_err, 1);
    chk("fto instret", instret, 1);
    do_reset("reset after fto");

    // rst while in WB of an add: no register or PC write that cycle.
    cyc(0, R, 0, 0, 0, 1, 1); chk_st("rwb fetch", 0, 7'b1001000);
    cyc(0, R, 0, 0, 0, 1, 1); chk_st("rwb decode", 1, 7'b0000000);
    cyc(0, R, 0, 0, 0, 1, 1); chk_st("rwb exec", 2, 7'b0000000);
    cyc(1, R, 0, 0, 0, 1, 1);
    chk("rwb state", state, 4);
    chk("rwb RegWrite", RegWrite, 0);
    chk("rwb PCWrite", PCWrite, 0);
    cyc(0, R, 0, 0, 0, 0, 1); chk_st("rwb after", 0, 7'b1000000);
    chk("rwb instret", instret, 0);

    // rst while a load is waiting in MEM: aborts, next cycle back in FETCH.
    cyc(0, LD, 0, 2, 0, 1, 0); chk_st("rmem fetch", 0, 7'b1001000);
    cyc(0, LD, 0, 2, 0, 1, 0); chk_st("rmem decode", 1, 7'b0000000);
    cyc(0, LD, 0, 2, 0, 1, 0); chk_st("rmem exec", 2, 7'b0000001);
    cyc(0, LD, 0, 2, 0, 1, 0); chk_st("rmem mem", 3, 7'b0100001);
    cyc(1, LD, 0, 2, 0, 1, 1);
    chk("rmem rst state", state, 3);
    chk("rmem rst strobes", stb, 7'b0000001);
    cyc(0, LD, 0, 2, 0, 1, 1); chk_st("rmem after", 0, 7'b1001000);
    chk("rmem instret", instret, 0);
    cyc(0, LD, 0, 2, 0, 1, 1); chk_st("rmem refetch", 1, 7'b0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle RV32I control unit, the successor to the single-cycle decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with ready-based handshakes to instruction and data memory. Produces per-state datapath strobes and detects illegal opcodes. Guards memory waits with a timeout and counts retired instructions. Sits between the IR/PC datapath and the memory bus wrapper.

Parameters:
ALUOP_W, 5, ALUOp width (≥5)
MEM_TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before trap (≥1)
CNT_W, 32, width of the instret counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Op  in  7  opcode from IR
Funct7  in  7  funct7 from IR
Funct3  in  3  funct3 from IR
Zero  in  1  ALU result == 0
imem_ready  in  1  instruction fetch complete
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
MemWrite  out  1  data write (valid with dmem_req)
IRWrite  out  1  latch instruction
PCWrite  out  1  update PC with NPCOp result
RegWrite  out  1  register file write
ALUSrc  out  1  ALU B = immediate
EXTOp  out  3  000 none, 001 S, 010 I, 011 U, 100 B, 101 J
ALUOp  out  ALUOP_W  0 nop, 1 lui, 2 auipc, 3 add, 4 sub, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 xor, 11 or, 12 and
NPCOp  out  3  000 PC+4, 001 branch target, 010 jal target, 100 jalr target
DMType  out  3  000 w, 001 h, 010 hu, 011 b, 100 bu
WDSel  out  2  00 ALU, 01 MEM, 10 PC+4
state  out  3  current state
illegal  out  1  sticky: illegal instruction trap
bus_err  out  1  sticky: memory timeout trap
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset: state=FETCH(0). illegal, bus_err, instret, wait counter and decode registers cleared. All strobes 0 except imem_req, which is a function of state and is therefore 1 in the cycle after reset. Reset mid-operation aborts without any PCWrite or RegWrite.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Strobes are combinational from state plus the registered decode; no strobe depends on Op directly outside DECODE.
- FETCH:
  - imem_req=1 until imem_ready.
  - On the ready cycle: IRWrite=1, next state DECODE.
- DECODE:
  - Registers the instruction class and ALUOp/EXTOp/DMType/branch kind.
  - Supported: R (10 ops), I-ALU incl. slli/srli/srai, loads lb/lh/lw/lbu/lhu, stores sb/sh/sw, 6 branches, jal, jalr, lui, auipc.
  - Any other Op/Funct3/Funct7 combination -> TRAP, illegal=1.
- EXEC, ALU class (R, I, lui, auipc):
  - Drives ALUOp/ALUSrc, then -> WB.
  - lui, auipc: EXTOp=U.
- EXEC, branch:
  - beq/bne: ALUOp=sub. blt/bge: ALUOp=slt. bltu/bgeu: ALUOp=sltu.
  - taken = Zero for beq/bge/bgeu; taken = !Zero for bne/blt/bltu.
  - PCWrite=1, NPCOp=001 if taken else 000, instret++, -> FETCH.
- EXEC, jal/jalr:
  - RegWrite=1, WDSel=10, PCWrite=1, NPCOp=010 or 100, instret++, -> FETCH.
- EXEC, load/store: ALUOp=add, ALUSrc=1, -> MEM.
- MEM:
  - dmem_req=1 (and MemWrite=1 for stores) held until dmem_ready.
  - On ready, store: PCWrite=1, NPCOp=000, instret++, -> FETCH.
  - On ready, load: -> WB.
- WB:
  - RegWrite=1. WDSel=01 for loads, 00 otherwise.
  - PCWrite=1, NPCOp=000, instret++, -> FETCH.
- Exactly one PCWrite and at most one RegWrite per instruction. instret wraps modulo 2^CNT_W.
- Timeout:
  - Counter clears on entering FETCH or MEM and increments each non-ready cycle.
  - Reaching MEM_TIMEOUT -> TRAP, bus_err=1, no strobes.
  - A ready arriving in the same cycle the count reaches MEM_TIMEOUT wins (no trap).
- TRAP: all strobes 0, stays until rst.
- Zero-wait latencies: R/I/lui/auipc 4 cycles, load 5, store 4, branch/jal/jalr 3.

Test Plan:
- add (0110011, f7 0, f3 0), ready always 1 -> states 0,1,2,4; ALUOp=3; RegWrite and PCWrite on cycle 4; instret=1.
- lw (0000011, f3 010), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles in MEM; WB with WDSel=01, DMType=000; total 8 cycles.
- bne with Zero=0, then again with Zero=1 -> first: NPCOp=001, PCWrite in EXEC; second: NPCOp=000; 3 cycles each.
- Op=7'b1111111 -> TRAP after DECODE, illegal=1; no PCWrite/RegWrite; stays in TRAP until rst.
- MEM_TIMEOUT=4, sw with dmem_ready never asserted -> bus_err=1 after 4 wait cycles. Repeat with ready on the 4th wait cycle -> no trap, store completes.
- rst during MEM of a load -> next cycle state=0, no RegWrite, instret unchanged.
